order_receiver: RTL and testbench
=================================

Name: order_receiver

Overview:
- Exchange-side deserializer that consumes the serial order stream (data line plus enable line) driven by the user-side transmitter.
- Synchronizes both inputs and samples one bit per bit period, mid-bit.
- Assembles 32-bit orders MSB first and buffers them in a small first-word-fall-through FIFO.
- Presents orders to the matching engine on a valid/ready handshake.

Parameters:
- BIT_CYCLES, 6: receiver clock cycles per serial bit; legal range >= 1; sample point HALF = BIT_CYCLES/2 (integer divide).
- FIFO_DEPTH, 4: number of buffered orders; power of two, >= 2.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_ping_in  input  1  serial order data, asynchronous to clock.
- comEn  input  1  frame enable, asynchronous to clock; high for the duration of one 32-bit frame.
- order_data  output  32  head-of-FIFO order word.
- order_valid  output  1  FIFO non-empty.
- order_ready  input  1  consumer accepts order_data when order_valid & order_ready.
- frame_err  output  1  one-cycle pulse when a frame is aborted.
- overflow  output  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of stored orders.
- busy  output  1  high while in RECV or DONE_WAIT.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - all outputs 0, order_data = 32'h0;
  - FIFO empty, state IDLE;
  - synchronizer flops 0.
- Synchronizer:
  - data_ping_in and comEn each pass through 2 flops, giving data_s and en_s.
  - Edge detect on en_s uses a third flop.
- State IDLE: rising edge of en_s -> RECV, with phase = 0, bitcnt = 0, shift = 0.
- State RECV:
  - phase increments each cycle and wraps from BIT_CYCLES-1 to 0.
  - When phase == HALF: shift <= {shift[30:0], data_s}, bitcnt++.
  - When bitcnt reaches 32, i.e. on the edge that samples bit 31: -> DONE_WAIT and push the word.
  - If en_s is 0 in any RECV cycle before the 32nd sample: frame_err = 1 for exactly one cycle, partial word discarded, -> IDLE.
- State DONE_WAIT:
  - Remain while en_s = 1.
  - en_s = 0 -> IDLE; no error.
  - A new frame requires a fresh en_s rising edge.
- Push:
  - Occurs on the edge after the bit-31 sample.
  - order_valid/order_data reflect the new word on that same edge when the FIFO was empty: latency 1 cycle from the bit-31 sample edge.
  - If the FIFO is full and no pop occurs that cycle: word dropped, overflow = 1 for one cycle, FIFO contents unchanged.
- Pop: on any edge where order_valid & order_ready; order_data advances to the next entry on that edge.
- Simultaneous push and pop:
  - Both honoured; fifo_count unchanged.
  - When full, the push is accepted, not an overflow.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_count ranges 0..FIFO_DEPTH.
- order_data holds its last value when empty. Consumers rely only on order_valid.
- Reset mid-frame or with FIFO data: everything cleared immediately, with no error or overflow pulse.
  - If comEn is still high after reset release, the first en_s sample sees a 0->1 edge only if the edge-detect flop reset to 0.
  - That edge is treated as a new frame start. It will most likely abort with frame_err, which is acceptable and specified.
- frame_err and overflow cannot both pulse for the same frame.

Test Plan:
- BIT_CYCLES=6; send 0x11004001 MSB first, 6 cycles/bit, comEn high 192 cycles, order_ready=0 -> order_valid rises 1 cycle after the 32nd sample edge; order_data=0x11004001; fifo_count=1; no frame_err or overflow.
- Four back-to-back frames 0xA5A5A5A5, 0x00000001, 0x80000000, 0xFFFFFFFF with order_ready=0 -> fifo_count=4. Then hold order_ready=1 -> same four words emerge in order on 4 consecutive edges; order_valid then low.
- Fifth frame 0x12345678 sent while the FIFO is full, order_ready=0 -> overflow pulses exactly 1 cycle; fifo_count stays 4; head still 0xA5A5A5A5.
- FIFO full and order_ready=1 on the exact push edge of 0x12345678 -> no overflow; fifo_count stays 4; the tail entry becomes 0x12345678.
- comEn dropped after 20 bits -> frame_err pulses 1 cycle; fifo_count unchanged. A following full frame 0xDEADBEEF is received correctly.
- Assert reset during bit 10 with 2 orders queued -> all outputs 0 asynchronously, fifo_count=0, busy=0. After release, a clean frame 0x0F0F0F0F is received correctly.

Source files
------------

// File: rtl/order_receiver.sv
// Serial order deserializer: synchronizes the data/enable lines, samples mid-bit,
// assembles 32-bit orders MSB first and queues them in a first-word-fall-through FIFO.
module order_receiver #(
  parameter int BIT_CYCLES = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        data_ping_in,
  input  logic                        comEn,
  output logic [31:0]                 order_data,
  output logic                        order_valid,
  input  logic                        order_ready,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(BIT_CYCLES / 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, DONE_WAIT} state_t;

  logic [2:0]    en_sync_q, en_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [5:0]    bitcnt_q, bitcnt_d;
  logic [31:0]   shift_q, shift_d;
  logic          push_q, push_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   head_q, head_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic en_s, en_d, data_s, pop, full, push_ok;

  assign en_s   = en_sync_q[1];
  assign en_d   = en_sync_q[2];
  assign data_s = dat_sync_q[1];

  always_comb begin
    en_sync_d  = {en_sync_q[1:0], comEn};
    dat_sync_d = {dat_sync_q[0], data_ping_in};
  end

  // Frame receiver; an abort always wins over a sample in the same cycle.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    push_d   = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      IDLE: if (en_s && !en_d) begin
        state_d  = RECV;
        phase_d  = '0;
        bitcnt_d = '0;
        shift_d  = '0;
      end
      RECV: if (!en_s) begin
        ferr_d  = 1'b1;
        state_d = IDLE;
      end else begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
        if (phase_q == PH_HALF) begin
          shift_d  = {shift_q[30:0], data_s};
          bitcnt_d = bitcnt_q + 6'd1;
          if (bitcnt_q == 6'd31) begin
            state_d = DONE_WAIT;
            push_d  = 1'b1;
          end
        end
      end
      DONE_WAIT: if (!en_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping; a pop on the push edge frees the slot a full FIFO needs.
  always_comb begin
    pop     = (count_q != '0) && order_ready;
    full    = (count_q == FULL_CNT);
    push_ok = push_q && (!full || pop);
    ovf_d   = push_q && full && !pop;
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
    head_d = head_q;
    if (count_d != '0)
      head_d = (push_ok && rd_d == wr_q) ? shift_q : mem_q[rd_d];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_sync_q  <= '0;
      dat_sync_q <= '0;
      state_q    <= IDLE;
      phase_q    <= '0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      head_q     <= '0;
    end else begin
      en_sync_q  <= en_sync_d;
      dat_sync_q <= dat_sync_d;
      state_q    <= state_d;
      phase_q    <= phase_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      push_q     <= push_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q] <= shift_q;
  end

  assign order_data  = head_q;
  assign order_valid = (count_q != '0);
  assign frame_err   = ferr_q;
  assign overflow    = ovf_q;
  assign fifo_count  = count_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_order_receiver.sv
// Directed bench for order_receiver: latency, FIFO ordering, overflow,
// push/pop on a full FIFO, frame abort and asynchronous reset.
module tb_order_receiver;
  localparam int BC = 6;
  localparam int FD = 4;

  logic        clock = 1'b0;
  logic        reset, data_ping_in, comEn, order_ready;
  logic [31:0] order_data;
  logic        order_valid, frame_err, overflow, busy;
  logic [$clog2(FD):0] fifo_count;

  int n_chk = 0, n_pass = 0;
  int err_cnt = 0, ovf_cnt = 0;
  int e0, o0;
  logic [31:0] w4 [4];
  logic [31:0] drain [4];

  order_receiver #(.BIT_CYCLES(BC), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .data_ping_in(data_ping_in), .comEn(comEn),
    .order_data(order_data), .order_valid(order_valid), .order_ready(order_ready),
    .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clock = ~clock;

  // Pulse-width monitor: counts cycles each pulse output is high.
  always @(posedge clock) begin
    if (frame_err) err_cnt <= err_cnt + 1;
    if (overflow)  ovf_cnt <= ovf_cnt + 1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits);
    comEn = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      data_ping_in = w[31-i];
      repeat (BC) tick();
    end
  endtask

  task automatic send_frame(input logic [31:0] w);
    send_bits(w, 32);
    comEn = 1'b0;
    data_ping_in = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    w4[0] = 32'hA5A5A5A5; w4[1] = 32'h00000001;
    w4[2] = 32'h80000000; w4[3] = 32'hFFFFFFFF;
    reset = 1'b1; data_ping_in = 1'b0; comEn = 1'b0; order_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", order_valid, 0);
    check("rst_data", order_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // single frame, latency one cycle after the bit-31 sample edge
    send_bits(32'h11004001, 32);
    comEn = 1'b0; data_ping_in = 1'b0;
    check("t1_valid_early", order_valid, 0);
    tick();
    check("t1_valid_sample", order_valid, 0);
    tick();
    check("t1_valid", order_valid, 1);
    check("t1_data", order_data, 32'h11004001);
    check("t1_count", fifo_count, 1);
    repeat (2) tick();
    check("t1_busy_idle", busy, 0);
    check("t1_ferr", err_cnt, 0);
    check("t1_ovf", ovf_cnt, 0);
    order_ready = 1'b1; tick(); order_ready = 1'b0;
    check("t1_pop_count", fifo_count, 0);
    check("t1_pop_valid", order_valid, 0);
    check("t1_hold_data", order_data, 32'h11004001);

    // four frames fill the FIFO, then drain in order
    for (int i = 0; i < 4; i++) send_frame(w4[i]);
    check("t2_count", fifo_count, 4);
    check("t2_head", order_data, 32'hA5A5A5A5);
    order_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain", order_data, w4[i]);
      tick();
    end
    order_ready = 1'b0;
    check("t2_empty_valid", order_valid, 0);
    check("t2_empty_count", fifo_count, 0);

    // fifth frame into a full FIFO is dropped
    for (int i = 0; i < 4; i++) send_frame(w4[i]);
    o0 = ovf_cnt;
    send_frame(32'h12345678);
    check("t3_ovf_pulse", ovf_cnt - o0, 1);
    check("t3_count", fifo_count, 4);
    check("t3_head", order_data, 32'hA5A5A5A5);
    check("t3_no_ferr", err_cnt, 0);

    // full FIFO with a pop on the exact push edge accepts the word
    send_bits(32'h12345678, 32);
    comEn = 1'b0; data_ping_in = 1'b0;
    tick();
    order_ready = 1'b1;
    tick();
    order_ready = 1'b0;
    repeat (3) tick();
    check("t4_no_ovf", ovf_cnt - o0, 1);
    check("t4_count", fifo_count, 4);
    check("t4_head", order_data, 32'h00000001);
    drain[0] = 32'h00000001; drain[1] = 32'h80000000;
    drain[2] = 32'hFFFFFFFF; drain[3] = 32'h12345678;
    order_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_drain", order_data, drain[i]);
      tick();
    end
    order_ready = 1'b0;
    check("t4_empty", fifo_count, 0);

    // comEn dropped after 20 bits aborts the frame
    e0 = err_cnt;
    send_bits(32'hCAFE1234, 20);
    comEn = 1'b0; data_ping_in = 1'b0;
    repeat (6) tick();
    check("t5_ferr_pulse", err_cnt - e0, 1);
    check("t5_count", fifo_count, 0);
    check("t5_busy", busy, 0);
    send_frame(32'hDEADBEEF);
    check("t5_next_count", fifo_count, 1);
    check("t5_next_data", order_data, 32'hDEADBEEF);
    check("t5_ferr_once", err_cnt - e0, 1);
    order_ready = 1'b1; tick(); order_ready = 1'b0;

    // asynchronous reset during bit 10 with two orders queued
    send_frame(32'hCAFEF00D);
    send_frame(32'h01234567);
    check("t6_count_pre", fifo_count, 2);
    send_bits(32'h55AA33CC, 10);
    data_ping_in = 1'b1;
    repeat (3) tick();
    check("t6_busy_pre", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", order_valid, 0);
    check("t6_rst_data", order_data, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ferr", frame_err, 0);
    check("t6_rst_ovf", overflow, 0);
    comEn = 1'b0; data_ping_in = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    e0 = err_cnt; o0 = ovf_cnt;
    repeat (4) tick();
    send_frame(32'h0F0F0F0F);
    check("t6_post_count", fifo_count, 1);
    check("t6_post_data", order_data, 32'h0F0F0F0F);
    check("t6_post_ferr", err_cnt - e0, 0);
    check("t6_post_ovf", ovf_cnt - o0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
